// File: rtl/accum_mem_arbiter.sv
// Purpose : arbitrates the single-port partial-sum SRAM between the pipeline write
//           port (never stalls), the pipeline read port and a valid/ready host port,
//           with a starvation guard that forces the host through.
// Latency : grants are combinational, so the SRAM access happens in the grant cycle.
//           Read data is registered the cycle after the access, so rvalid is seen
//           2 cycles after the grant.
// Backpressure: pipe_we is always served. pipe_re is held off by pipe_rgnt=0.
//           The host holds its request until host_ready.
// Ports   : clk, arst_n_in        clock and async active-low reset
//           pipe_we/waddr/wdata   pipeline write (always granted)
//           pipe_re/raddr/rgnt    pipeline read request and accept
//           pipe_rdata/rvalid     pipeline read return
//           host_valid/wr/addr/wdata/ready   host request and accept
//           host_rdata/rvalid     host read return
//           sram_*                SRAM macro interface
//           starve_cnt            host starvation count (debug)
module accum_mem_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              arst_n_in,
  // pipeline write port
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  // pipeline read port
  input  logic              pipe_re,
  input  logic [ADDR_W-1:0] pipe_raddr,
  output logic              pipe_rgnt,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_rvalid,
  // host port
  input  logic              host_valid,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  // SRAM macro
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  // debug
  output logic [7:0]        starve_cnt
);

  typedef enum logic {
    ARB_PIPE = 1'b0,
    ARB_HOST = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_PIPE = 2'd1,
    TAG_HOST = 2'd2
  } ret_tag_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  localparam logic [7:0] CNT_MAX = 8'hFF;

  arb_state_t state_q, state_d;
  ret_tag_t   tag_q, tag_d;
  logic [7:0] cnt_q, cnt_d;

  logic gnt_pipe_wr;
  logic gnt_pipe_rd;
  logic gnt_host;

  // Grant selection. The pipeline read slot only exists in ARB_PIPE. In ARB_HOST
  // the host is the only competitor left against the pipeline write.
  always_comb begin
    gnt_pipe_wr = 1'b0;
    gnt_pipe_rd = 1'b0;
    gnt_host    = 1'b0;
    if (pipe_we) begin
      gnt_pipe_wr = 1'b1;
    end else if (state_q == ARB_PIPE && pipe_re) begin
      gnt_pipe_rd = 1'b1;
    end else if (host_valid) begin
      gnt_host = 1'b1;
    end
  end

  assign pipe_rgnt  = gnt_pipe_rd;
  assign host_ready = gnt_host;

  // SRAM drive. An idle cycle leaves the address and data on the pipeline write bus.
  always_comb begin
    sram_en    = gnt_pipe_wr | gnt_pipe_rd | gnt_host;
    sram_we    = gnt_pipe_wr | (gnt_host & host_wr);
    sram_addr  = pipe_waddr;
    sram_wdata = pipe_wdata;
    if (gnt_pipe_rd) begin
      sram_addr = pipe_raddr;
    end else if (gnt_host) begin
      sram_addr  = host_addr;
      sram_wdata = host_wdata;
    end
  end

  // Remember who owns the read that the SRAM answers next cycle.
  always_comb begin
    tag_d = TAG_NONE;
    if (gnt_pipe_rd) begin
      tag_d = TAG_PIPE;
    end else if (gnt_host && !host_wr) begin
      tag_d = TAG_HOST;
    end
  end

  // Starvation count and next state. Once the host slot is forced, only a
  // pipeline write can still deny the host. The count then holds at the limit.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (!host_valid || gnt_host) begin
      cnt_d = 8'd0;
    end else if (state_q == ARB_PIPE && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end

    case (state_q)
      ARB_PIPE: begin
        if (host_valid && !gnt_host && cnt_d >= LIMIT) begin
          state_d = ARB_HOST;
        end
      end
      ARB_HOST: begin
        if (!host_valid || gnt_host) begin
          state_d = ARB_PIPE;
        end
      end
      default: state_d = ARB_PIPE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q <= ARB_PIPE;
      cnt_q   <= 8'd0;
      tag_q   <= TAG_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
    end
  end

  // Read return. Resetting the tag drops any read that was in flight.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      pipe_rdata  <= '0;
      pipe_rvalid <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      pipe_rvalid <= (tag_q == TAG_PIPE);
      host_rvalid <= (tag_q == TAG_HOST);
      if (tag_q == TAG_PIPE) begin
        pipe_rdata <= sram_rdata;
      end
      if (tag_q == TAG_HOST) begin
        host_rdata <= sram_rdata;
      end
    end
  end

  assign starve_cnt = cnt_q;

endmodule

// File: doc/accum_mem_arbiter.md
Name: accum_mem_arbiter

Overview:
- Shares the single-port partial-sum SRAM among three requesters:
  - the conv controller's pipelined accumulator write port, which cannot stall;
  - the controller's accumulator read port, which can stall;
  - a host readout/debug port using a valid/ready handshake.
- Sits between the controller FSM / MAC datapath and the SRAM macro.
- Provides one access per cycle, fixed-priority arbitration, and a starvation guard for the host.
- Routes 1-cycle-latency read data back to the requester that issued the read.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 32, SRAM word width.
- STARVE_LIMIT, 8, consecutive denied host cycles before the host is forced through; legal range 1..255.

Ports:
- clk  in  1  clock.
- arst_n_in  in  1  asynchronous reset, active-low.
- pipe_we  in  1  pipeline write request; always served.
- pipe_waddr  in  ADDR_W  pipeline write address.
- pipe_wdata  in  DATA_W  pipeline write data.
- pipe_re  in  1  pipeline read request.
- pipe_raddr  in  ADDR_W  pipeline read address.
- pipe_rgnt  out  1  pipeline read accepted this cycle.
- pipe_rdata  out  DATA_W  pipeline read data.
- pipe_rvalid  out  1  pipe_rdata valid.
- host_valid  in  1  host request present.
- host_wr  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ready  out  1  host request accepted this cycle.
- host_rdata  out  DATA_W  host read data.
- host_rvalid  out  1  host_rdata valid.
- sram_en  out  1  SRAM access enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read access.
- starve_cnt  out  8  current host starvation count (debug).

Behaviour:
- Reset (async, arst_n_in low):
  - state = ARB_PIPE; starvation counter = 0.
  - pipe_rvalid = 0, host_rvalid = 0; rdata registers = 0.
  - Return-tag register = NONE.
  - Combinational outputs are inactive while no request is present.
- Reset mid-operation:
  - In-flight read data is dropped; no rvalid pulses after reset.
  - The requester must reissue.
- States:
  - ARB_PIPE (normal).
  - ARB_HOST (forced host slot).
- Per-cycle grant in ARB_PIPE, priority order:
  1. pipe_we.
  2. pipe_re.
  3. host_valid.
  - Exactly one grant per cycle.
- Per-cycle grant in ARB_HOST, priority order:
  1. pipe_we.
  2. host_valid.
  - pipe_rgnt is forced to 0 in this state.
- Pipeline writes:
  - pipe_we always wins, in both states.
  - sram_en = 1, sram_we = 1, address and data passed through the same cycle.
- Grant handshakes:
  - pipe_rgnt is combinational: pipe_re && granted.
  - host_ready is combinational: host_valid && granted.
  - The host must hold addr/wr/wdata stable until host_ready.
- Read return:
  - Tag register records PIPE, HOST or NONE at each granted read.
  - The next cycle, sram_rdata is registered into pipe_rdata or host_rdata.
  - The matching rvalid pulses for 1 cycle, 2 cycles after grant. Total read latency from grant = 2 cycles.
  - Back-to-back reads give one rvalid per cycle.
- Host writes: no response; completion is the host_ready cycle.
- Starvation counter:
  - Saturating; increments when host_valid && !host_ready.
  - Clears when host_ready = 1 or host_valid = 0.
  - ARB_PIPE -> ARB_HOST when the counter reaches STARVE_LIMIT.
  - ARB_HOST -> ARB_PIPE on the cycle after host_ready, or immediately when host_valid drops.
  - While pipe_we persists in ARB_HOST, the arbiter stays in ARB_HOST and the counter holds (no increment past STARVE_LIMIT).
- Same-cycle address hazards:
  - Pipeline write plus host read of the same address: the write wins, and the host is served a later cycle, reading the new value.
  - No forwarding logic; single-port serialisation guarantees ordering.
- Idle cycles: sram_en = 0, sram_we = 0; sram_addr and sram_wdata are don't-care, driven with pipe_waddr/pipe_wdata.

Test Plan:
- Reset, then pipe_we addr 0x10 data 0xAAAA0001, then pipe_re addr 0x10 -> pipe_rgnt = 1 same cycle; pipe_rvalid 2 cycles later with 0xAAAA0001; host_rvalid stays 0.
- Same cycle pipe_we (0x20, 5), pipe_re (0x21) and host read (0x22) -> only the write is granted. Next cycle pipe_rgnt = 1, then host_ready = 1 the cycle after. rvalids arrive in order PIPE, HOST.
- pipe_re held high continuously with host_valid high, STARVE_LIMIT = 8:
  - host_ready = 0 for exactly 8 cycles; starve_cnt reaches 8.
  - 9th cycle host_ready = 1 and pipe_rgnt = 0.
  - Back to ARB_PIPE afterwards; starve_cnt = 0.
- Forced host slot with pipe_we asserted for 3 cycles -> writes all land; host_ready delayed 3 cycles; pipe_rgnt stays 0 throughout.
- Host write 0x5 <- 0xDEADBEEF, then host read 0x5 -> host_rvalid with 0xDEADBEEF at 2 cycles after the read grant.
- arst_n_in pulsed the cycle after a granted pipeline read -> no pipe_rvalid; state ARB_PIPE; starve_cnt = 0.
